// File: rtl/kernel_host_pkg.sv
// Shared types and default widths for the kernel host sequencer.
// The defaults match the generated kernel this host drives.
package kernel_host_pkg;

    localparam int KH_DEPTH    = 2;
    localparam int KH_ADDR_W   = 1;
    localparam int KH_DATA_W   = 1;
    localparam int KH_INIT_W   = 1;
    localparam int KH_RESULT_W = 2;
    localparam int KH_TIMEOUT  = 1024;

    typedef enum logic [2:0] {
        KH_IDLE,
        KH_LOAD,
        KH_START,
        KH_RUN,
        KH_RD_ADDR,
        KH_RD_CAP,
        KH_DUMP,
        KH_RESP
    } kh_state_t;

endpackage

// File: rtl/kernel_host_seq_if.sv
// Command, load/dump stream, response and kernel-pin bundle of the host sequencer.
// master is the sequencer side; slave is the fabric plus kernel side.
interface kernel_host_seq_if import kernel_host_pkg::*; #(
    parameter int ADDR_W   = KH_ADDR_W,
    parameter int DATA_W   = KH_DATA_W,
    parameter int INIT_W   = KH_INIT_W,
    parameter int RESULT_W = KH_RESULT_W
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [INIT_W-1:0]   cmd_init;
    logic                cmd_load;

    logic                ld_valid;
    logic                ld_ready;
    logic [DATA_W-1:0]   ld_data;

    logic                dump_valid;
    logic                dump_ready;
    logic [DATA_W-1:0]   dump_data;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [RESULT_W-1:0] rsp_result;
    logic                rsp_timeout;

    logic                k_r_enable;
    logic [INIT_W-1:0]   k_init;
    logic                k_w_enable;
    logic [RESULT_W-1:0] k_result;
    logic                k_control_arr;
    logic                k_arr_wen;
    logic [ADDR_W-1:0]   k_arr_addr;
    logic [DATA_W-1:0]   k_arr_wdata;
    logic [DATA_W-1:0]   k_arr_rdata;

    logic                busy;

    modport master (
        input  cmd_valid, cmd_init, cmd_load, ld_valid, ld_data, dump_ready, rsp_ready,
               k_w_enable, k_result, k_arr_rdata,
        output cmd_ready, ld_ready, dump_valid, dump_data, rsp_valid, rsp_result, rsp_timeout,
               k_r_enable, k_init, k_control_arr, k_arr_wen, k_arr_addr, k_arr_wdata, busy
    );

    modport slave (
        output cmd_valid, cmd_init, cmd_load, ld_valid, ld_data, dump_ready, rsp_ready,
               k_w_enable, k_result, k_arr_rdata,
        input  cmd_ready, ld_ready, dump_valid, dump_data, rsp_valid, rsp_result, rsp_timeout,
               k_r_enable, k_init, k_control_arr, k_arr_wen, k_arr_addr, k_arr_wdata, busy
    );

endinterface

// File: rtl/kernel_watchdog.sv
// Cycle watchdog for a kernel run: cleared before RUN, counts while enabled.
// expired is high in the enabled cycle where the count reaches TIMEOUT-1.
module kernel_watchdog import kernel_host_pkg::*; #(
    parameter int TIMEOUT = KH_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int              CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating so an idle watchdog left enabled can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/kernel_host_seq.sv
// Host sequencer: load array, start kernel, watchdog the run, dump array, respond.
// Load 1 cycle/word, dump 3 cycles/word; ld/dump/rsp stall indefinitely with outputs held.
module kernel_host_seq import kernel_host_pkg::*; #(
    parameter int DEPTH    = KH_DEPTH,
    parameter int ADDR_W   = KH_ADDR_W,
    parameter int DATA_W   = KH_DATA_W,
    parameter int INIT_W   = KH_INIT_W,
    parameter int RESULT_W = KH_RESULT_W,
    parameter int TIMEOUT  = KH_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    kernel_host_seq_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    kh_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [INIT_W-1:0]   init_q, init_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                wd_clr, wd_en, wd_expired;

    assign wd_clr = (state_q == KH_START);
    assign wd_en  = (state_q == KH_RUN);

    kernel_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_d    = init_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        hold_d    = hold_q;
        case (state_q)
            KH_IDLE: begin
                if (bus.cmd_valid) begin
                    init_d  = bus.cmd_init;
                    cnt_d   = '0;
                    state_d = bus.cmd_load ? KH_LOAD : KH_START;
                end
            end
            KH_LOAD: begin
                if (bus.ld_valid) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = KH_START;
                    end
                end
            end
            KH_START: state_d = KH_RUN;
            KH_RUN: begin
                // A done seen on the watchdog's last cycle still wins over the abort.
                if (bus.k_w_enable) begin
                    result_d  = bus.k_result;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = KH_RD_ADDR;
                end else if (wd_expired) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = KH_RESP;
                end
            end
            KH_RD_ADDR: state_d = KH_RD_CAP;
            KH_RD_CAP: begin
                hold_d  = bus.k_arr_rdata;
                state_d = KH_DUMP;
            end
            KH_DUMP: begin
                if (bus.dump_ready) begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = (cnt_q == LAST_ADDR) ? KH_RESP : KH_RD_ADDR;
                end
            end
            KH_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = KH_IDLE;
                end
            end
            default: state_d = KH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= KH_IDLE;
            cnt_q     <= '0;
            init_q    <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_q    <= init_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    // Every output is a state decode or a register; write strobe and data only follow ld in LOAD.
    assign bus.cmd_ready     = (state_q == KH_IDLE);
    assign bus.ld_ready      = (state_q == KH_LOAD);
    assign bus.dump_valid    = (state_q == KH_DUMP);
    assign bus.dump_data     = hold_q;
    assign bus.rsp_valid     = (state_q == KH_RESP);
    assign bus.rsp_result    = result_q;
    assign bus.rsp_timeout   = timeout_q;
    assign bus.busy          = (state_q != KH_IDLE);
    assign bus.k_r_enable    = (state_q == KH_START);
    assign bus.k_init        = init_q;
    assign bus.k_control_arr = (state_q == KH_LOAD) || (state_q == KH_RD_ADDR) ||
                               (state_q == KH_RD_CAP) || (state_q == KH_DUMP);
    assign bus.k_arr_wen     = (state_q == KH_LOAD) && bus.ld_valid;
    assign bus.k_arr_addr    = cnt_q;
    assign bus.k_arr_wdata   = (state_q == KH_LOAD) ? bus.ld_data : '0;

endmodule

// File: tb/tb_kernel_host_seq.sv
// Bench for kernel_host_seq with a behavioural kernel (array memory, tunable latency, hang mode).
module tb_kernel_host_seq;
    import kernel_host_pkg::*;

    localparam int DEPTH = 2, ADDR_W = 1, DATA_W = 1, INIT_W = 1, RESULT_W = 2, TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kernel_host_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_W(INIT_W), .RESULT_W(RESULT_W)) bus ();

    kernel_host_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_W(INIT_W),
                      .RESULT_W(RESULT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Kernel model: done appears k_lat cycles into RUN; result = mem0+mem1+init, then mem ^= init.
    logic        km_mem [DEPTH] = '{default: 1'b0};
    logic        km_rdata = 1'b0;
    logic        km_done  = 1'b0;
    logic        km_run   = 1'b0;
    logic [1:0]  km_res   = 2'b0;
    int          km_cnt   = 0;
    int          k_lat    = 3;
    bit          k_hang   = 1'b0;

    assign bus.k_w_enable  = km_done;
    assign bus.k_result    = km_res;
    assign bus.k_arr_rdata = km_rdata;

    always @(posedge clk) begin
        if (bus.k_control_arr) begin
            if (bus.k_arr_wen) km_mem[bus.k_arr_addr] <= bus.k_arr_wdata;
            km_rdata <= km_mem[bus.k_arr_addr];
        end
        if (bus.k_r_enable) begin
            km_done <= 1'b0;
            km_cnt  <= 1;
            km_run  <= !k_hang;
        end else if (km_run) begin
            if (km_cnt >= k_lat) begin
                km_done <= 1'b1;
                km_run  <= 1'b0;
                km_res  <= 2'(km_mem[0]) + 2'(km_mem[1]) + 2'(bus.k_init);
                for (int i = 0; i < DEPTH; i++) km_mem[i] <= km_mem[i] ^ bus.k_init;
            end else begin
                km_cnt <= km_cnt + 1;
            end
        end
    end

    // Golden kernel state and scoreboard queues.
    logic gold_mem [DEPTH] = '{default: 1'b0};

    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
    typedef struct { logic [RESULT_W-1:0] res; logic to; } rsp_t;
    wr_t                exp_wr   [$];
    logic [DATA_W-1:0]  exp_dump [$];
    rsp_t               exp_rsp  [$];

    task automatic kernel_apply(input logic init, output logic [1:0] res);
        res = 2'(gold_mem[0]) + 2'(gold_mem[1]) + 2'(init);
        for (int i = 0; i < DEPTH; i++) gold_mem[i] = gold_mem[i] ^ init;
    endtask

    task automatic run_cmd(input string name, input logic init, input logic load,
                           input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                           input bit stall, input bit exp_to, input int exp_run);
        logic [DATA_W-1:0]   words [DEPTH];
        logic [1:0]          res;
        wr_t                 w;
        rsp_t                r;
        logic [DATA_W-1:0]   d;
        int                  ld_idx = 0;
        int                  pulses = 0;
        int                  run_cyc = 0;
        bit                  accepted = 0, finished = 0, counting = 0, saw_ld_ready = 0;
        bit                  dump_stall = 0, rsp_stall = 0;
        logic [DATA_W-1:0]   dump_prev = '0;
        logic [RESULT_W-1:0] rsp_prev_res = '0;
        logic                rsp_prev_to = 1'b0;
        words[0] = w0;
        words[1] = w1;
        if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                gold_mem[i] = words[i];
                w.addr = ADDR_W'(i);
                w.data = words[i];
                exp_wr.push_back(w);
            end
        end
        if (exp_to) begin
            r.res = '0; r.to = 1'b1;
        end else begin
            kernel_apply(init, res);
            for (int i = 0; i < DEPTH; i++) exp_dump.push_back(gold_mem[i]);
            r.res = res; r.to = 1'b0;
        end
        exp_rsp.push_back(r);

        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk);
            bus.cmd_valid  = !accepted;
            bus.cmd_init   = init;
            bus.cmd_load   = load;
            bus.ld_valid   = accepted && load && (ld_idx < DEPTH) && (!stall || $urandom_range(0, 2) != 0);
            bus.ld_data    = (ld_idx < DEPTH) ? words[ld_idx] : '0;
            bus.dump_ready = !stall || $urandom_range(0, 2) == 0;
            bus.rsp_ready  = !stall || $urandom_range(0, 3) == 0;
            #1;
            if (counting) begin
                if (bus.k_control_arr || bus.rsp_valid) counting = 0;
                else run_cyc++;
            end
            if (bus.k_r_enable) begin
                pulses++;
                counting = 1;
            end
            if (bus.ld_ready) saw_ld_ready = 1;
            if (bus.ld_valid || bus.k_arr_wen) begin
                checks++;
                if (bus.k_arr_wen !== (bus.ld_valid && bus.ld_ready)) begin
                    errors++;
                    $display("FAIL %s wen_vs_ld: wen=%b ld_valid=%b ld_ready=%b", name, bus.k_arr_wen, bus.ld_valid, bus.ld_ready);
                end
            end
            if (bus.k_arr_wen) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_write: addr=%0d data=%0d, no write expected", name, bus.k_arr_addr, bus.k_arr_wdata);
                end else begin
                    w = exp_wr.pop_front();
                    if (bus.k_arr_addr !== w.addr || bus.k_arr_wdata !== w.data || bus.k_control_arr !== 1'b1) begin
                        errors++;
                        $display("FAIL %s write: addr=%0d data=%0d ctl=%b, want addr=%0d data=%0d ctl=1",
                                 name, bus.k_arr_addr, bus.k_arr_wdata, bus.k_control_arr, w.addr, w.data);
                    end
                end
            end
            if (bus.ld_valid && bus.ld_ready) ld_idx++;
            if (dump_stall) begin
                checks++;
                if (bus.dump_valid !== 1'b1 || bus.dump_data !== dump_prev) begin
                    errors++;
                    $display("FAIL %s dump_stable: valid=%b data=%0d, want valid=1 data=%0d", name, bus.dump_valid, bus.dump_data, dump_prev);
                end
            end
            if (bus.dump_valid && bus.dump_ready) begin
                checks++;
                if (exp_dump.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_dump: data=%0d, no dump expected", name, bus.dump_data);
                end else begin
                    d = exp_dump.pop_front();
                    if (bus.dump_data !== d) begin
                        errors++;
                        $display("FAIL %s dump_word: got %0d want %0d", name, bus.dump_data, d);
                    end
                end
            end
            dump_stall = bus.dump_valid && !bus.dump_ready;
            dump_prev  = bus.dump_data;
            if (rsp_stall) begin
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== rsp_prev_res || bus.rsp_timeout !== rsp_prev_to) begin
                    errors++;
                    $display("FAIL %s rsp_stable: valid=%b res=%0d to=%b, want valid=1 res=%0d to=%b",
                             name, bus.rsp_valid, bus.rsp_result, bus.rsp_timeout, rsp_prev_res, rsp_prev_to);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                checks++;
                r = exp_rsp.pop_front();
                if (bus.rsp_result !== r.res || bus.rsp_timeout !== r.to || bus.k_init !== init) begin
                    errors++;
                    $display("FAIL %s rsp: res=%0d to=%b k_init=%b, want res=%0d to=%b k_init=%b",
                             name, bus.rsp_result, bus.rsp_timeout, bus.k_init, r.res, r.to, init);
                end
                finished = 1;
            end
            rsp_stall    = bus.rsp_valid && !bus.rsp_ready;
            rsp_prev_res = bus.rsp_result;
            rsp_prev_to  = bus.rsp_timeout;
            if (bus.cmd_valid && bus.cmd_ready) accepted = 1;
        end
        @(negedge clk);
        bus.cmd_valid = 0; bus.ld_valid = 0; bus.dump_ready = 0; bus.rsp_ready = 0;

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s no_response: no rsp within cycle budget", name);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s start_pulses: got %0d want 1", name, pulses);
        end
        checks++;
        if (run_cyc != exp_run) begin
            errors++;
            $display("FAIL %s run_cycles: got %0d want %0d", name, run_cyc, exp_run);
        end
        checks++;
        if (exp_wr.size() != 0 || exp_dump.size() != 0) begin
            errors++;
            $display("FAIL %s missing: writes left=%0d dumps left=%0d want 0", name, exp_wr.size(), exp_dump.size());
        end
        checks++;
        if (saw_ld_ready !== load) begin
            errors++;
            $display("FAIL %s ld_ready_seen: got %b want %b", name, saw_ld_ready, load);
        end
        exp_wr.delete();
        exp_dump.delete();
        exp_rsp.delete();
    endtask

    task automatic test_reset();
        logic [14:0] ov;
        #2;
        ov = {bus.cmd_ready, bus.ld_ready, bus.dump_valid, bus.rsp_valid, bus.busy, bus.k_r_enable,
              bus.k_control_arr, bus.k_arr_wen, bus.k_arr_addr, bus.k_arr_wdata, bus.dump_data,
              bus.rsp_result, bus.rsp_timeout, bus.k_init};
        checks++;
        if (ov !== 15'h4000) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 4000", ov);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b want 1/0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_load_run_dump();
        run_cmd("load_run_dump", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    endtask

    task automatic test_no_load();
        run_cmd("no_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) run_cmd("backpressure", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    endtask

    task automatic test_timeout();
        k_hang = 1'b1;
        run_cmd("timeout", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, TIMEOUT);
        k_hang = 1'b0;
    endtask

    task automatic test_done_at_limit();
        k_lat = TIMEOUT - 1;
        run_cmd("done_at_limit", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, TIMEOUT);
        k_lat = 3;
    endtask

    task automatic test_reset_mid_run();
        logic [14:0] ov;
        logic [1:0]  res;
        bit          seen = 0;
        int          ld_idx = 0;
        logic [DATA_W-1:0] words [DEPTH];
        words[0] = 1'b0;
        words[1] = 1'b1;
        for (int i = 0; i < DEPTH; i++) gold_mem[i] = words[i];
        kernel_apply(1'b1, res);
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_init = 1'b1; bus.cmd_load = 1'b1;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            bus.cmd_valid  = 0;
            bus.dump_ready = 0;
            bus.ld_valid   = (ld_idx < DEPTH);
            bus.ld_data    = (ld_idx < DEPTH) ? words[ld_idx] : '0;
            #1;
            if (bus.ld_valid && bus.ld_ready) ld_idx++;
            if (bus.dump_valid) seen = 1;
        end
        bus.ld_valid = 0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_run_reach_dump: dump_valid not seen within budget");
        end
        #2;
        rst_n = 1'b0;
        #1;
        ov = {bus.cmd_ready, bus.ld_ready, bus.dump_valid, bus.rsp_valid, bus.busy, bus.k_r_enable,
              bus.k_control_arr, bus.k_arr_wen, bus.k_arr_addr, bus.k_arr_wdata, bus.dump_data,
              bus.rsp_result, bus.rsp_timeout, bus.k_init};
        checks++;
        if (ov !== 15'h4000) begin
            errors++;
            $display("FAIL reset_mid_run_outputs: got %h want 4000", ov);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    endtask

    initial begin
        bus.cmd_valid  = 0;
        bus.cmd_init   = '0;
        bus.cmd_load   = 0;
        bus.ld_valid   = 0;
        bus.ld_data    = '0;
        bus.dump_ready = 0;
        bus.rsp_ready  = 0;
        test_reset();
        test_load_run_dump();
        test_no_load();
        test_backpressure();
        test_timeout();
        test_done_at_limit();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kernel_host_seq.md
# kernel_host_seq

Host-side sequencer for one synthesized kernel and its array memory. It accepts a run command and streams the initial array contents into the memory through the kernel's array control port. It then starts the kernel, waits for completion under a watchdog, and streams the final array contents out alongside the kernel result. It sits between the system command/stream fabric and a generated kernel top, and is the only agent that drives the kernel's start, control and array-control pins.

## Interface

Parameters:
- DEPTH, 2: array words loaded and dumped per run (addresses 0..DEPTH-1).
- ADDR_W, 1: array address width; must satisfy 2**ADDR_W >= DEPTH.
- DATA_W, 1: array word width.
- INIT_W, 1: kernel init argument width.
- RESULT_W, 2: kernel result width.
- TIMEOUT, 1024: maximum RUN cycles before abort; must be >= 1.

Ports:
- clk  in  1  the single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  run request.
- cmd_ready  out  1  high only in IDLE.
- cmd_init  in  INIT_W  kernel argument, captured on the cmd handshake.
- cmd_load  in  1  1 = load DEPTH words before start; 0 = keep the current memory contents.
- ld_valid / ld_ready  in / out  1  load stream handshake.
- ld_data  in  DATA_W  load word; words arrive in address order.
- dump_valid / dump_ready  out / in  1  dump stream handshake.
- dump_data  out  DATA_W  dumped word, in address order.
- rsp_valid / rsp_ready  out / in  1  completion handshake.
- rsp_result  out  RESULT_W  kernel result latched at completion.
- rsp_timeout  out  1  1 = watchdog abort; rsp_result is then 0.
- k_r_enable  out  1  kernel start/reset strobe.
- k_init  out  INIT_W  kernel argument.
- k_w_enable  in  1  kernel done level.
- k_result  in  RESULT_W  kernel result.
- k_control_arr  out  1  1 = the host owns the array port.
- k_arr_wen  out  1  array write enable.
- k_arr_addr  out  ADDR_W  array address.
- k_arr_wdata  out  DATA_W  array write data.
- k_arr_rdata  in  DATA_W  array read data; valid one cycle after a read address is presented.
- busy  out  1  high whenever the state is not IDLE.

## Operation

States: IDLE, LOAD, START, RUN, RD_ADDR, RD_CAP, DUMP, RESP.

- **IDLE:** on the cmd handshake, capture cmd_init, clear the address counter, and go to LOAD if cmd_load=1, otherwise to START.
- **LOAD:** ld_ready=1, k_control_arr=1, k_arr_wen = ld_valid, k_arr_addr = counter, k_arr_wdata = ld_data.
  - Each accepted word increments the counter.
  - After the word at DEPTH-1 is accepted, go to START.
- **START:** k_control_arr=0, k_r_enable=1 for exactly one cycle, then go to RUN and clear the watchdog.
- **RUN:** k_control_arr=0, and the watchdog counts once per cycle.
  - If k_w_enable=1: latch k_result, clear rsp_timeout, clear the counter, go to RD_ADDR.
  - Else, if the watchdog equals TIMEOUT-1: rsp_timeout=1, rsp_result=0, go to RESP and skip the dump.
  - Done takes priority over timeout in the same cycle.
- **RD_ADDR:** k_control_arr=1, k_arr_wen=0, k_arr_addr = counter. Go to RD_CAP.
- **RD_CAP:** k_control_arr=1; register k_arr_rdata into the dump holding register. Go to DUMP.
- **DUMP:** dump_valid=1, and dump_data comes from the holding register.
  - On handshake, increment the counter.
  - Go to RD_ADDR, or to RESP after index DEPTH-1.
- **RESP:** rsp_valid=1 with stable rsp_result and rsp_timeout. On handshake, go to IDLE.

Output rules:
- k_init holds the captured cmd_init from the cmd handshake until the next command.
- k_control_arr=0 in IDLE, START and RUN.
- k_arr_wen is asserted only in LOAD.

## Timing

- Reset is asynchronous, with all outputs low:
  - state=IDLE, so cmd_ready=1 after reset;
  - ld_ready, dump_valid, rsp_valid, busy, k_r_enable, k_control_arr and k_arr_wen = 0;
  - counters, rsp_result, rsp_timeout and k_init = 0.
- Deassertion of rst_n mid-run abandons the run; the kernel keeps its own state until the next k_r_enable.
- All outputs are registered or decoded from state only. There is no combinational path from a ready input to a valid output.
- The first RUN cycle always sees k_w_enable=0, because the kernel clears it on the r_enable edge. A stale done flag from the previous run is therefore never accepted.
- LOAD takes a minimum of DEPTH cycles with ld_valid held high.
- Dump takes a minimum of 3 cycles per word with dump_ready held high.
- Command-to-RESP minimum is 1 + DEPTH + 1 + kernel cycles + 3·DEPTH.
- Backpressure: any number of stall cycles is allowed on ld, dump and rsp, and all outputs hold stable while stalled.

## Structure

- Shared package kernel_host_pkg holds the state enum kh_state_t and the default localparams for the widths.
- One natural sub-module: kernel_watchdog (clear, enable, expire at TIMEOUT-1). The counter width is $clog2(TIMEOUT)+1.

## Test plan

Use DEPTH=2, DATA_W=1 and RESULT_W=2 against the generated kernel.

- **Load, run, dump:** cmd_init=1, cmd_load=1, load {1,0} -> exactly 2 writes (addresses 0 and 1), one k_r_enable pulse, then 2 dump words and 1 rsp with rsp_timeout=0 and rsp_result equal to the kernel's golden-model result.
- **No load:** cmd_load=0 right after scenario 1 -> no ld_ready, START follows IDLE directly, dump reflects the memory left by the previous run.
- **Backpressure:** random ld_valid/dump_ready/rsp_ready gaps -> identical words and result to the no-stall run, with outputs stable during stalls.
- **Timeout:** kernel stub holding k_w_enable=0, TIMEOUT=8 -> RUN lasts exactly 8 cycles, rsp_timeout=1, rsp_result=0, no dump.
- **Done at limit:** k_w_enable rises on watchdog count TIMEOUT-1 -> done wins, rsp_timeout=0, dump proceeds.
- **Reset mid-run:** assert rst_n low during DUMP -> all outputs 0 within the same cycle; a new cmd is accepted once rst_n is released.
